mem_access_ctrl: RTL and testbench

- Parametrised controller that puts N CPU memory requesters behind the single MMU port. Default: port 0 = MEM-stage data access, port 1 = IF-stage fetch.
- Arbitrates between requesters, holds one outstanding access on the MMU handshake and returns responses to the owning port.
- Raises errors on misaligned accesses and on MMU timeouts.
- Supplies the busy/stall information the hazard unit needs.

---
 rtl/mem_access_ctrl_pkg.sv | 27 ++
 rtl/mem_access_ctrl_if.sv | 42 ++++
 rtl/mem_access_ctrl_arbiter.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: MMU width codes, arbitration modes, FSM states.
package mem_access_ctrl_pkg;

  localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MMU_WIDTH_WORD = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    MAC_IDLE   = 2'd0,
    MAC_ACCESS = 2'd1,
    MAC_RESP   = 2'd2
  } mac_state_t;

  // Unknown width codes are treated as aligned and left for the MMU to judge.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lsb);
    case (width)
      MMU_WIDTH_BYTE: return 1'b0;
      MMU_WIDTH_HALF: return addr_lsb[0];
      MMU_WIDTH_WORD: return |addr_lsb;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester and MMU bus bundle; slave = controller view, master = requester/MMU environment view.
interface mem_access_ctrl_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS-1:0]            req_signed;
  logic [2*NUM_PORTS-1:0]          req_width;
  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr;
  logic [DATA_WIDTH*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic                            resp_err;
  logic [DATA_WIDTH-1:0]           resp_rdata;
  logic                            busy;
  logic                            mmu_mem_ready;
  logic [DATA_WIDTH-1:0]           mmu_data_out;
  logic                            mmu_read_enable;
  logic                            mmu_write_enable;
  logic                            mmu_mem_signed_read;
  logic [1:0]                      mmu_mem_data_width;
  logic [ADDR_WIDTH-1:0]           mmu_address;
  logic [DATA_WIDTH-1:0]           mmu_data_in;

  modport slave (
    input  req_valid, req_write, req_signed, req_width, req_addr, req_wdata,
    input  mmu_mem_ready, mmu_data_out,
    output req_ready, resp_valid, resp_err, resp_rdata, busy,
    output mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
    output mmu_mem_data_width, mmu_address, mmu_data_in
  );

  modport master (
    output req_valid, req_write, req_signed, req_width, req_addr, req_wdata,
    output mmu_mem_ready, mmu_data_out,
    input  req_ready, resp_valid, resp_err, resp_rdata, busy,
    input  mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
    input  mmu_mem_data_width, mmu_address, mmu_data_in
  );
endinterface

// File: rtl/mem_access_ctrl_arbiter.sv
// Combinational requester arbiter: fixed lowest-index priority or round robin starting after ptr.
module mac_arbiter
  import mem_access_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 rr_mode,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

  // Both searches walk from the least preferred candidate so the last hit is the winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    if (rr_mode) begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        int j;
        j = (int'(ptr) + k) % NUM_PORTS;
        if (req[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Puts NUM_PORTS CPU requesters behind one MMU port with one outstanding access at a time.
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winner
// ACCESS | MMU strobed from latched request; wait for ready, timeout or misalign flush
// RESP   | one-cycle response pulse to the owning port
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic clk,
  input logic reset,
  mem_access_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  mac_state_t            state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic                  lat_write;
  logic                  lat_mis;
  logic [31:0]           cnt;

  logic [NUM_PORTS-1:0]  grant;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_write;
  logic                  win_signed;
  logic [1:0]            win_width;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_mis;
  logic                  timed_out;

  mac_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .rr_mode(ARB_MODE != ARB_FIXED),
    .grant  (grant),
    .idx    (win_idx)
  );

  assign win_write  = bus.req_write[win_idx];
  assign win_signed = bus.req_signed[win_idx];
  assign win_width  = bus.req_width[2*int'(win_idx) +: 2];
  assign win_addr   = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata  = bus.req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_mis    = is_misaligned(win_width, win_addr[1:0]);
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));

  assign bus.req_ready = (state == MAC_IDLE) ? grant : '0;

  // A misaligned request still passes through ACCESS for one cycle with strobes held low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= MAC_IDLE;
      ptr                     <= IDX_W'(NUM_PORTS - 1);
      owner                   <= '0;
      lat_write               <= 1'b0;
      lat_mis                 <= 1'b0;
      cnt                     <= '0;
      bus.mmu_read_enable     <= 1'b0;
      bus.mmu_write_enable    <= 1'b0;
      bus.mmu_mem_signed_read <= 1'b0;
      bus.mmu_mem_data_width  <= MMU_WIDTH_WORD;
      bus.mmu_address         <= '0;
      bus.mmu_data_in         <= '0;
      bus.resp_valid          <= '0;
      bus.resp_err            <= 1'b0;
      bus.resp_rdata          <= '0;
      bus.busy                <= 1'b0;
    end else begin
      bus.resp_valid <= '0;
      case (state)
        MAC_IDLE: begin
          if (|bus.req_valid) begin
            owner                   <= win_idx;
            ptr                     <= win_idx;
            lat_write               <= win_write;
            lat_mis                 <= win_mis;
            bus.mmu_mem_signed_read <= win_signed;
            bus.mmu_mem_data_width  <= win_width;
            bus.mmu_address         <= win_addr;
            bus.mmu_data_in         <= win_wdata;
            bus.mmu_read_enable     <= !win_mis && !win_write;
            bus.mmu_write_enable    <= !win_mis && win_write;
            bus.busy                <= 1'b1;
            cnt                     <= '0;
            state                   <= MAC_ACCESS;
          end
        end
        MAC_ACCESS: begin
          if (lat_mis || bus.mmu_mem_ready || timed_out) begin
            bus.mmu_read_enable  <= 1'b0;
            bus.mmu_write_enable <= 1'b0;
            bus.resp_valid       <= NUM_PORTS'(1) << owner;
            bus.resp_err         <= lat_mis || !bus.mmu_mem_ready;
            bus.resp_rdata       <= (!lat_mis && bus.mmu_mem_ready && !lat_write) ?
                                    bus.mmu_data_out : '0;
            state                <= MAC_RESP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        MAC_RESP: begin
          cnt      <= '0;
          bus.busy <= 1'b0;
          state    <= MAC_IDLE;
        end
        default: state <= MAC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: a fixed-priority (timeout 5) and a round-robin (no timeout) controller share stimulus.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TO_FIX = 5;

  typedef struct {
    int          g;
    int          wc;
    int          n_rd;
    int          n_wr;
    int          rcyc;
    bit          stable;
    logic [1:0]  rvec;
    logic        err;
    logic [31:0] rdat;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_signed;
  logic [3:0]  req_width;
  logic [63:0] req_addr, req_wdata;
  logic        mmu_mem_ready;
  logic [31:0] mmu_data_out;
  bit          sel;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) f_bus ();
  mem_access_ctrl_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) r_bus ();

  assign f_bus.req_valid     = req_valid;
  assign f_bus.req_write     = req_write;
  assign f_bus.req_signed    = req_signed;
  assign f_bus.req_width     = req_width;
  assign f_bus.req_addr      = req_addr;
  assign f_bus.req_wdata     = req_wdata;
  assign f_bus.mmu_mem_ready = mmu_mem_ready;
  assign f_bus.mmu_data_out  = mmu_data_out;
  assign r_bus.req_valid     = req_valid;
  assign r_bus.req_write     = req_write;
  assign r_bus.req_signed    = req_signed;
  assign r_bus.req_width     = req_width;
  assign r_bus.req_addr      = req_addr;
  assign r_bus.req_wdata     = req_wdata;
  assign r_bus.mmu_mem_ready = mmu_mem_ready;
  assign r_bus.mmu_data_out  = mmu_data_out;

  mem_access_ctrl #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                    .ARB_MODE(ARB_FIXED), .TIMEOUT_CYCLES(TO_FIX))
    dut_fix (.clk(clk), .reset(reset), .bus(f_bus.slave));

  mem_access_ctrl #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                    .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(0))
    dut_rr (.clk(clk), .reset(reset), .bus(r_bus.slave));

  logic [1:0]  o_ready, o_rvalid, o_w;
  logic        o_err, o_busy, o_rd, o_wr, o_sg;
  logic [31:0] o_rdat, o_addr, o_din;
  assign o_ready  = sel ? r_bus.req_ready          : f_bus.req_ready;
  assign o_rvalid = sel ? r_bus.resp_valid         : f_bus.resp_valid;
  assign o_err    = sel ? r_bus.resp_err           : f_bus.resp_err;
  assign o_rdat   = sel ? r_bus.resp_rdata         : f_bus.resp_rdata;
  assign o_busy   = sel ? r_bus.busy               : f_bus.busy;
  assign o_rd     = sel ? r_bus.mmu_read_enable    : f_bus.mmu_read_enable;
  assign o_wr     = sel ? r_bus.mmu_write_enable   : f_bus.mmu_write_enable;
  assign o_sg     = sel ? r_bus.mmu_mem_signed_read: f_bus.mmu_mem_signed_read;
  assign o_w      = sel ? r_bus.mmu_mem_data_width : f_bus.mmu_mem_data_width;
  assign o_addr   = sel ? r_bus.mmu_address        : f_bus.mmu_address;
  assign o_din    = sel ? r_bus.mmu_data_in        : f_bus.mmu_data_in;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    mmu_mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int p, input logic wr, input logic sg, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
    req_write[p] = wr;
    req_signed[p] = sg;
    req_width[2*p +: 2] = w;
    req_addr[p*32 +: 32] = a;
    req_wdata[p*32 +: 32] = d;
    req_valid[p] = 1'b1;
  endtask

  // Runs one access: finds the grant, drops that port's valid, drives mmu_mem_ready in
  // strobe cycle ready_at (0 = never) and records what the selected controller does.
  task automatic txn(input int ready_at, input logic [31:0] rd, output obs_t o);
    logic [31:0] ea, ed;
    logic [1:0]  ew;
    logic        es;
    o = '{g: -1, wc: -1, n_rd: 0, n_wr: 0, rcyc: -1, stable: 1'b1,
          rvec: 2'b00, err: 1'b0, rdat: 32'h0};
    for (int c = 0; c < 8 && o.g < 0; c++) begin
      @(negedge clk);
      if (o_ready == 2'b01) o.g = 0;
      else if (o_ready == 2'b10) o.g = 1;
      if (o.g >= 0) o.wc = c;
      else step();
    end
    if (o.g >= 0) begin
      ea = req_addr[o.g*32 +: 32];
      ed = req_wdata[o.g*32 +: 32];
      ew = req_width[2*o.g +: 2];
      es = req_signed[o.g];
      step();
      req_valid[o.g] = 1'b0;
      for (int n = 1; n <= 20 && o.rcyc < 0; n++) begin
        mmu_mem_ready = (n == ready_at);
        mmu_data_out  = (n == ready_at) ? rd : $urandom;
        @(negedge clk);
        if (o_rd) o.n_rd++;
        if (o_wr) o.n_wr++;
        if ((o_rd || o_wr) && (o_addr !== ea || o_din !== ed || o_w !== ew || o_sg !== es))
          o.stable = 1'b0;
        if (o_rvalid !== 2'b00) begin
          o.rcyc = n;
          o.rvec = o_rvalid;
          o.err  = o_err;
          o.rdat = o_rdat;
        end
        step();
      end
      mmu_mem_ready = 1'b0;
    end
  endtask

  function automatic int rr_pick(input logic [1:0] pend, input int last);
    for (int k = 1; k <= 2; k++) begin
      if (pend[(last + k) % 2]) return (last + k) % 2;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    mmu_mem_ready = 1'b0;
    mmu_data_out = 32'hFFFF_FFFF;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset busy[%0d]: got %b want 0", s, o_busy); end
      n_cmp++; if ({o_rd, o_wr} !== 2'b00) begin n_bad++; $display("FAIL reset strobes[%0d]: got %b want 00", s, {o_rd, o_wr}); end
      n_cmp++; if (o_w !== MMU_WIDTH_WORD) begin n_bad++; $display("FAIL reset width[%0d]: got %0d want %0d", s, o_w, MMU_WIDTH_WORD); end
      n_cmp++; if ({o_addr, o_din} !== 64'h0) begin n_bad++; $display("FAIL reset addr/data[%0d]: got %h want 0", s, {o_addr, o_din}); end
      n_cmp++; if ({o_rvalid, o_err, o_rdat} !== 35'h0) begin n_bad++; $display("FAIL reset resp[%0d]: got %h want 0", s, {o_rvalid, o_err, o_rdat}); end
      n_cmp++; if (o_ready !== 2'b00) begin n_bad++; $display("FAIL reset ready[%0d]: got %b want 00", s, o_ready); end
    end
    do_reset();
  endtask

  task automatic test_fixed_priority();
    obs_t o;
    logic [31:0] rd;
    sel = 1'b0;
    do_reset();
    set_req(0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h100, 32'h0);
    set_req(1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h000, 32'h0);
    rd = $urandom;
    txn(2, rd, o);
    n_cmp++; if (o.g !== 0 || o.wc !== 0) begin n_bad++; $display("FAIL fixed first grant: got port %0d wait %0d want port 0 wait 0", o.g, o.wc); end
    n_cmp++; if (o.rcyc !== 3 || o.rvec !== 2'b01) begin n_bad++; $display("FAIL fixed first resp: got cycle %0d vec %b want 3 01", o.rcyc, o.rvec); end
    n_cmp++; if (o.rdat !== rd || o.err !== 1'b0) begin n_bad++; $display("FAIL fixed first data: got %h err %b want %h err 0", o.rdat, o.err, rd); end
    n_cmp++; if (o.n_rd !== 2 || !o.stable) begin n_bad++; $display("FAIL fixed first strobe: got %0d stable %b want 2 1", o.n_rd, o.stable); end
    rd = $urandom;
    txn(1, rd, o);
    n_cmp++; if (o.g !== 1 || o.wc !== 0) begin n_bad++; $display("FAIL fixed second grant: got port %0d wait %0d want port 1 wait 0", o.g, o.wc); end
    n_cmp++; if (o.rvec !== 2'b10 || o.rdat !== rd) begin n_bad++; $display("FAIL fixed second resp: got %b %h want 10 %h", o.rvec, o.rdat, rd); end
  endtask

  task automatic test_rr_alternate();
    obs_t o;
    int prev = -1;
    sel = 1'b1;
    do_reset();
    set_req(0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h0);
    set_req(1, 1'b0, 1'b1, MMU_WIDTH_HALF, 32'h22, 32'h0);
    for (int i = 0; i < 6; i++) begin
      txn(1, $urandom, o);
      n_cmp++; if (o.g !== i % 2 || o.g == prev || o.wc !== 0) begin n_bad++; $display("FAIL rr alternate %0d: got port %0d wait %0d want port %0d wait 0", i, o.g, o.wc, i % 2); end
      if (o.g >= 0) begin
        req_valid[o.g] = 1'b1;
        prev = o.g;
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_store();
    obs_t o;
    sel = 1'b0;
    do_reset();
    set_req(0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h200, 32'hDEAD_BEEF);
    txn(4, $urandom, o);
    n_cmp++; if (o.n_wr !== 4 || o.n_rd !== 0 || !o.stable) begin n_bad++; $display("FAIL store strobes: got wr %0d rd %0d stable %b want 4 0 1", o.n_wr, o.n_rd, o.stable); end
    n_cmp++; if (o.rcyc !== 5 || o.rvec !== 2'b01 || o.err !== 1'b0 || o.rdat !== 32'h0) begin n_bad++; $display("FAIL store resp: got cyc %0d vec %b err %b data %h want 5 01 0 0", o.rcyc, o.rvec, o.err, o.rdat); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    sel = 1'b0;
    do_reset();
    set_req(0, 1'b0, 1'b1, MMU_WIDTH_HALF, 32'h103, 32'h0);
    txn(1, 32'h1234_5678, o);
    n_cmp++; if (o.n_rd !== 0 || o.n_wr !== 0) begin n_bad++; $display("FAIL misalign half strobes: got rd %0d wr %0d want 0 0", o.n_rd, o.n_wr); end
    n_cmp++; if (o.rcyc !== 2 || o.err !== 1'b1 || o.rdat !== 32'h0) begin n_bad++; $display("FAIL misalign half resp: got cyc %0d err %b data %h want 2 1 0", o.rcyc, o.err, o.rdat); end
    set_req(1, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h102, 32'h5555_AAAA);
    txn(1, 32'h0, o);
    n_cmp++; if (o.n_wr !== 0 || o.rcyc !== 2 || o.err !== 1'b1 || o.rvec !== 2'b10) begin n_bad++; $display("FAIL misalign word: got wr %0d cyc %0d err %b vec %b want 0 2 1 10", o.n_wr, o.rcyc, o.err, o.rvec); end
    set_req(0, 1'b0, 1'b0, MMU_WIDTH_BYTE, 32'h103, 32'h0);
    txn(1, 32'hCAFE_0042, o);
    n_cmp++; if (o.n_rd !== 1 || o.rcyc !== 2 || o.err !== 1'b0 || o.rdat !== 32'hCAFE_0042) begin n_bad++; $display("FAIL byte odd addr: got rd %0d cyc %0d err %b data %h want 1 2 0 cafe0042", o.n_rd, o.rcyc, o.err, o.rdat); end
  endtask

  task automatic test_timeout();
    obs_t o;
    sel = 1'b0;
    do_reset();
    set_req(0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h40, 32'h0);
    txn(0, 32'h0, o);
    n_cmp++; if (o.n_rd !== TO_FIX || o.rcyc !== TO_FIX + 1) begin n_bad++; $display("FAIL timeout strobe: got %0d cyc %0d want %0d %0d", o.n_rd, o.rcyc, TO_FIX, TO_FIX + 1); end
    n_cmp++; if (o.err !== 1'b1 || o.rdat !== 32'h0) begin n_bad++; $display("FAIL timeout resp: got err %b data %h want 1 0", o.err, o.rdat); end
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL timeout busy after: got %b want 0", o_busy); end
    step();
    set_req(1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h44, 32'h0);
    txn(TO_FIX, 32'h7777_0001, o);
    n_cmp++; if (o.err !== 1'b0 || o.rdat !== 32'h7777_0001 || o.n_rd !== TO_FIX) begin n_bad++; $display("FAIL timeout edge ready: got err %b data %h rd %0d want 0 77770001 %0d", o.err, o.rdat, o.n_rd, TO_FIX); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    sel = 1'b1;
    do_reset();
    set_req(1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h80, 32'h0);
    txn(1, $urandom, o);
    n_cmp++; if (o.g !== 1) begin n_bad++; $display("FAIL rst-mid lone port1: got %0d want 1", o.g); end
    set_req(0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h84, 32'h1111_2222);
    @(negedge clk);
    n_cmp++; if (o_ready !== 2'b01) begin n_bad++; $display("FAIL rst-mid grant: got %b want 01", o_ready); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (o_wr !== 1'b1) begin n_bad++; $display("FAIL rst-mid strobe before: got %b want 1", o_wr); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({o_rd, o_wr, o_busy} !== 3'b000 || o_rvalid !== 2'b00) begin n_bad++; $display("FAIL rst-mid after: got rd/wr/busy %b vec %b want 000 00", {o_rd, o_wr, o_busy}, o_rvalid); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      n_cmp++; if (o_rvalid !== 2'b00) begin n_bad++; $display("FAIL rst-mid stray resp %0d: got %b want 00", i, o_rvalid); end
    end
    step();
    set_req(0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h90, 32'h0);
    set_req(1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h94, 32'h0);
    txn(1, $urandom, o);
    n_cmp++; if (o.g !== 0) begin n_bad++; $display("FAIL rst-mid fresh grant: got %0d want 0", o.g); end
    txn(1, $urandom, o);
    req_valid = 2'b00;
  endtask

  // Random traffic; requests stay pending (unchanged) until granted.
  task automatic test_random(input bit s, input int n);
    obs_t        o;
    logic [1:0]  pend = 2'b00;
    logic        pwr[2], psg[2];
    logic [1:0]  pw[2];
    logic [31:0] pa[2], pd[2];
    int          last = 1;
    int          eg, ra, eff, to_val, ercyc, ens;
    logic        mis, tmo, eerr;
    logic [31:0] rd, erd;
    sel = s;
    to_val = s ? 0 : TO_FIX;
    do_reset();
    for (int t = 0; t < n; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pwr[p] = 1'($urandom_range(0, 1));
          psg[p] = 1'($urandom_range(0, 1));
          pw[p]  = 2'($urandom_range(0, 2));
          pa[p]  = $urandom & 32'h0000_0FFF;
          pd[p]  = $urandom;
          set_req(p, pwr[p], psg[p], pw[p], pa[p], pd[p]);
          pend[p] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        pwr[0] = 1'b0; psg[0] = 1'b0; pw[0] = MMU_WIDTH_BYTE;
        pa[0] = $urandom & 32'hFFF; pd[0] = $urandom;
        set_req(0, pwr[0], psg[0], pw[0], pa[0], pd[0]);
        pend[0] = 1'b1;
      end
      eg = s ? rr_pick(pend, last) : (pend[0] ? 0 : 1);
      ra = s ? $urandom_range(1, 6) : $urandom_range(0, 7);
      rd = $urandom;
      mis = (pw[eg] == MMU_WIDTH_HALF && pa[eg][0]) ||
            (pw[eg] == MMU_WIDTH_WORD && pa[eg][1:0] != 2'b00);
      tmo = !mis && (ra == 0 || (to_val != 0 && ra > to_val));
      eff = mis ? 0 : (tmo ? to_val : ra);
      ercyc = mis ? 2 : eff + 1;
      eerr = mis || tmo;
      erd = (eerr || pwr[eg]) ? 32'h0 : rd;
      ens = eff;
      txn(ra, rd, o);
      n_cmp++; if (o.g !== eg || o.wc !== 0) begin n_bad++; $display("FAIL rnd%0d[%0d] grant: got port %0d wait %0d want port %0d wait 0", s, t, o.g, o.wc, eg); end
      n_cmp++; if (o.n_rd !== (pwr[eg] ? 0 : ens) || o.n_wr !== (pwr[eg] ? ens : 0)) begin n_bad++; $display("FAIL rnd%0d[%0d] strobes: got rd %0d wr %0d want %0d cycles write=%b", s, t, o.n_rd, o.n_wr, ens, pwr[eg]); end
      n_cmp++; if (!o.stable) begin n_bad++; $display("FAIL rnd%0d[%0d] mmu fields: got unstable want latched request", s, t); end
      n_cmp++; if (o.rcyc !== ercyc || o.rvec !== (2'b01 << eg)) begin n_bad++; $display("FAIL rnd%0d[%0d] resp timing: got cyc %0d vec %b want %0d port %0d", s, t, o.rcyc, o.rvec, ercyc, eg); end
      n_cmp++; if (o.err !== eerr || o.rdat !== erd) begin n_bad++; $display("FAIL rnd%0d[%0d] resp data: got err %b %h want %b %h", s, t, o.err, o.rdat, eerr, erd); end
      pend[eg] = 1'b0;
      last = eg;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    req_valid = '0; req_write = '0; req_signed = '0; req_width = '0;
    req_addr = '0; req_wdata = '0;
    mmu_mem_ready = 1'b0;
    mmu_data_out = '0;
    test_reset();
    test_fixed_priority();
    test_rr_alternate();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
